// File: rtl/counter.sv
// Prescaled up/down counter with switch-selected mode, heartbeat flag
// and a 4-bit LED window onto the count.
module counter #(
    parameter int clk_freq  = 125000000,
    parameter int BIT_WIDTH = 31,
    parameter int R         = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw,
    output logic        rgb,
    output logic [3:0]  led,
    output logic [31:0] counter_out
);

    localparam int PW = (clk_freq > 1) ? $clog2(clk_freq) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(clk_freq - 1);

    logic [PW-1:0]      p;
    logic               tick;
    logic [BIT_WIDTH:0] cnt;
    logic [BIT_WIDTH:0] cnt_next;

    assign tick = (p == P_LAST);

    // free-running prescaler, never realigned by mode changes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0;
        end else if (tick) begin
            p <= '0;
        end else begin
            p <= p + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb <= 1'b0;
        end else if (tick) begin
            rgb <= ~rgb;
        end
    end

    always_comb begin
        cnt_next = cnt;
        if (sw[3]) begin
            cnt_next = '0;
        end else if (sw[2]) begin
            cnt_next = cnt;
        end else if (sw[1]) begin
            if (tick) begin
                cnt_next = cnt - 1'b1;
            end
        end else if (sw[0]) begin
            cnt_next = cnt + 1'b1;
        end else if (tick) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign counter_out = 32'(cnt);
    assign led         = counter_out[R:R-3];

endmodule

// File: tb/tb_counter.sv
// Randomised and directed check of counter against a per-edge
// arithmetic model; a second instance covers the narrow-width case.
module tb_counter;

    logic        clk;
    logic        rst;
    logic [3:0]  sw;
    logic [3:0]  sw2;
    logic        rgb;
    logic        rgb2;
    logic [3:0]  led;
    logic [3:0]  led2;
    logic [31:0] counter_out;
    logic [31:0] counter_out2;

    int passed;
    int total;

    longint edges;
    longint m1;
    longint m2;
    bit     m_rgb;
    bit     was_tick;

    localparam longint M1 = 64'h1_0000_0000;
    localparam longint M2 = 256;

    counter #(.clk_freq(8), .BIT_WIDTH(31), .R(31)) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .rgb(rgb),
        .led(led),
        .counter_out(counter_out)
    );

    counter #(.clk_freq(8), .BIT_WIDTH(7), .R(3)) dut2 (
        .clk(clk),
        .rst(rst),
        .sw(sw2),
        .rgb(rgb2),
        .led(led2),
        .counter_out(counter_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic longint nxt(input longint c, input logic [3:0] s,
                                   input bit t, input longint m);
        if (s[3]) return 0;
        if (s[2]) return c;
        if (s[1]) return t ? (c + m - 1) % m : c;
        if (s[0]) return (c + 1) % m;
        return t ? (c + 1) % m : c;
    endfunction

    task automatic model_reset();
        edges = 0;
        m1 = 0;
        m2 = 0;
        m_rgb = 1'b0;
    endtask

    task automatic check_model();
        logic [31:0] e1;
        logic [31:0] e2;
        e1 = m1[31:0];
        e2 = m2[31:0];
        chk("cnt", counter_out, e1);
        chk("led", {28'b0, led}, {28'b0, e1[31:28]});
        chk("rgb", {31'b0, rgb}, {31'b0, m_rgb});
        chk("cnt_w8", counter_out2, e2);
        chk("led_w8", {28'b0, led2}, {28'b0, e2[3:0]});
        chk("rgb_w8", {31'b0, rgb2}, {31'b0, m_rgb});
    endtask

    // one rising edge, model advanced with the inputs in force, then checked
    task automatic step();
        @(posedge clk);
        edges++;
        was_tick = (edges % 8 == 0);
        if (was_tick) m_rgb = ~m_rgb;
        m1 = nxt(m1, sw, was_tick, M1);
        m2 = nxt(m2, sw2, was_tick, M2);
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b0;
        sw = 4'h0;
        sw2 = 4'h0;
        model_reset();
        #1;
        check_model();
        chk("reset_cnt", counter_out, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        run(80);
        chk("tick80_cnt", counter_out, 32'd10);
        chk("tick80_rgb", {31'b0, rgb}, 32'd0);
        chk("tick80_led", {28'b0, led}, 32'd0);
        run(8);
        chk("tick88_cnt", counter_out, 32'd11);
        chk("tick88_rgb", {31'b0, rgb}, 32'd1);

        sw = 4'h1;
        run(100);
        chk("fast_cnt", counter_out, 32'd111);

        for (int i = 0; i < 400; i++) begin
            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) sw[3] = 1'b0;
            sw2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) sw2[3] = 1'b0;
            step();
        end

        sw = 4'h8;
        sw2 = 4'h4;
        step();
        chk("clear", counter_out, 32'h0);
        sw = 4'h2;
        was_tick = 1'b0;
        for (int i = 0; i < 8 && !was_tick; i++) step();
        chk("down_wrap_tick", {31'b0, was_tick}, 32'd1);
        chk("down_wrap_cnt", counter_out, 32'hFFFF_FFFF);
        chk("down_wrap_led", {28'b0, led}, 32'hF);

        sw = 4'h4;
        run(100);
        chk("hold_cnt", counter_out, 32'hFFFF_FFFF);
        sw = 4'h8;
        step();
        chk("clr_cnt", counter_out, 32'h0);
        sw = 4'hF;
        run(20);
        chk("all_sw_cnt", counter_out, 32'h0);

        sw = 4'h1;
        run(5);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_cnt", counter_out, 32'h0);
        chk("async_led", {28'b0, led}, 32'h0);
        chk("async_rgb", {31'b0, rgb}, 32'h0);
        check_model();
        @(negedge clk);
        sw = 4'h0;
        sw2 = 4'h0;
        rst = 1'b1;
        run(7);
        chk("rel7_rgb", {31'b0, rgb}, 32'd0);
        chk("rel7_cnt", counter_out, 32'd0);
        step();
        chk("rel8_rgb", {31'b0, rgb}, 32'd1);
        chk("rel8_cnt", counter_out, 32'd1);

        sw = 4'h4;
        sw2 = 4'h8;
        step();
        sw2 = 4'h1;
        run(254);
        chk("w8_fe", counter_out2, 32'hFE);
        step();
        chk("w8_ff", counter_out2, 32'hFF);
        chk("w8_ff_led", {28'b0, led2}, 32'hF);
        step();
        chk("w8_00", counter_out2, 32'h0);
        chk("w8_00_led", {28'b0, led2}, 32'h0);
        chk("w8_upper", {8'b0, counter_out2[31:8]}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter clk_freq, default 125000000: prescaler period in clock cycles, one tick per clk_freq cycles; legal range >= 1.
REQ-002 Parameter BIT_WIDTH, default 31: MSB index of the main counter, so the counter is BIT_WIDTH+1 bits wide; legal range 3..31.
REQ-003 Parameter R, default 31: MSB index of the 4-bit LED window; legal range 3..BIT_WIDTH.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 sw  input  4  mode select (see Function).
REQ-008 rgb  output  1  heartbeat flag, registered.
REQ-009 led  output  4  counter window counter_out[R:R-3], combinational from the counter register.
REQ-010 counter_out  output  32  main counter value, registered; bits above BIT_WIDTH are driven 0.

Function
REQ-011 Prescaler p SHALL be a register that counts 0..clk_freq-1 every clock and wraps to 0, independent of sw.
REQ-012 tick SHALL be combinational and equal 1 when p == clk_freq-1; with clk_freq=1, tick is 1 every cycle.
REQ-013 rgb SHALL toggle on every clock edge where tick=1, regardless of sw.
REQ-014 Counter update priority SHALL be evaluated every rising edge, highest priority first:
  - sw[3]=1: clear counter to 0.
  - else sw[2]=1: hold.
  - else sw[1]=1: decrement by 1 on tick edges only.
  - else sw[0]=1: increment by 1 on every edge (fast mode, ignores tick).
  - else (sw=0): increment by 1 on tick edges only.
REQ-015 Arithmetic SHALL be modulo 2^(BIT_WIDTH+1): increment from all-ones wraps to 0; decrement from 0 wraps to all-ones.
REQ-016 sw SHALL be sampled directly, without synchronisation or debouncing; a mode change takes effect on the next rising edge.
REQ-017 A mode change SHALL NOT reset or realign the prescaler.
REQ-018 led SHALL follow counter_out[R:R-3] in the same cycle, with no additional latency.
REQ-019 Unknown (X) sw values are out of scope; the bench SHALL drive sw to a defined value before the first rising edge after reset release.

Reset
REQ-020 While rst=0, p, counter, and rgb SHALL be 0 immediately, without waiting for a clock edge; led and counter_out therefore read 0.
REQ-021 Reset asserted mid-operation SHALL discard all state; after release, p restarts at 0, so the first tick occurs on the clk_freq-th rising edge after release.
REQ-022 Reset release SHALL take effect on the next rising edge; no edge-alignment of the release is required.

Verification (clk_freq=8, BIT_WIDTH=31, R=31 unless stated)
REQ-023 Async reset: count to a nonzero value, drive rst=0 between edges -> counter_out=0, led=0, rgb=0 before the next edge.
REQ-024 Tick counting: release reset with sw=0 and run 80 rising edges -> counter_out=10, rgb=0 (10 toggles), led=0; after 8 more edges -> 11, rgb=1.
REQ-025 Fast mode: from counter_out=N, sw=1 for 100 edges -> counter_out=N+100; rgb still toggles once per 8 edges.
REQ-026 Down/wrap: from 0, sw=2 until the first tick -> counter_out=32'hFFFFFFFF, led=4'hF.
REQ-027 Priority: sw=4 for 100 edges -> counter_out unchanged; sw=8 -> 0 on the next edge; sw=4'hF -> stays 0.
REQ-028 Width: with BIT_WIDTH=7, R=3, sw=1 from 8'hFE -> FF then 00, with counter_out[31:8]=0 throughout and led tracking counter_out[3:0].
